// File: rtl/pending_priority_encoder_if.sv
// Grant handshake between the pending priority encoder and its single consumer.
// The producer presents out_idx/out_onehot under out_valid and the consumer accepts with out_ready.
interface pending_priority_encoder_if #(
  parameter int unsigned N = 8
) ();
  localparam int unsigned IDX_W = $clog2(N);

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     out_onehot;

  modport master (
    output out_valid,
    output out_idx,
    output out_onehot,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_onehot,
    output out_ready
  );
endinterface

// File: rtl/pending_priority_encoder.sv
// Registered N-input priority encoder with sticky pending requests, masking and a valid/ready grant.
// Optional macro PPE_OVERFLOW_EN adds sticky per-input overflow flags for requests merged into a pending bit.
module pending_priority_encoder #(
  parameter int unsigned N           = 8,
  parameter bit          ROUND_ROBIN = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N-1:0]                      req_i,
  input  logic [N-1:0]                      mask_i,
  pending_priority_encoder_if.master        out_if,
  output logic [N-1:0]                      pending,
  output logic                              any_pend
`ifdef PPE_OVERFLOW_EN
  ,
  input  logic                              ovf_clr_i,
  output logic [N-1:0]                      overflow
`endif
);

  localparam int unsigned IDX_W = $clog2(N);

  logic             accept;
  logic             slot_free;
  logic [N-1:0]     clr;
  logic [N-1:0]     cand;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;

  logic [N-1:0]     pending_nxt;
  logic             out_valid_nxt;
  logic [IDX_W-1:0] out_idx_nxt;
  logic [N-1:0]     out_onehot_nxt;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] last_nxt;

  // Accept decode; the accepted bit is excluded from both re-selection and the pending hold term.
  always_comb begin
    accept    = out_if.out_valid && out_if.out_ready;
    clr       = accept ? out_if.out_onehot : '0;
    slot_free = !out_if.out_valid || accept;
    cand      = pending & ~mask_i & ~clr;
  end

  assign any_pend = |(pending & ~mask_i);

  generate
    if (ROUND_ROBIN) begin : g_rr
      // Descending search starting one below the last accepted index, wrapping N-1 after 0.
      always_comb begin
        int unsigned      pos;
        logic [IDX_W-1:0] pos_idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        pos       = 0;
        pos_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
          pos     = (32'(last) + N - 1 - k) % N;
          pos_idx = IDX_W'(pos);
          if (!sel_found && cand[pos_idx]) begin
            sel_found = 1'b1;
            sel_idx   = pos_idx;
          end
        end
      end
    end else begin : g_fixed
      // Highest set index wins: later iterations overwrite earlier ones.
      always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
          if (cand[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
          end
        end
      end
    end
  endgenerate

  // Next-state: pending merge, grant slot refill and rotation pointer.
  always_comb begin
    pending_nxt    = (pending & ~clr) | req_i;
    out_valid_nxt  = out_if.out_valid;
    out_idx_nxt    = out_if.out_idx;
    out_onehot_nxt = out_if.out_onehot;
    last_nxt       = accept ? out_if.out_idx : last;
    if (slot_free) begin
      if (sel_found) begin
        out_valid_nxt  = 1'b1;
        out_idx_nxt    = sel_idx;
        out_onehot_nxt = N'(1) << sel_idx;
      end else begin
        out_valid_nxt  = 1'b0;
        out_onehot_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending           <= '0;
      out_if.out_valid  <= 1'b0;
      out_if.out_idx    <= '0;
      out_if.out_onehot <= '0;
      last              <= '0;
    end else begin
      pending           <= pending_nxt;
      out_if.out_valid  <= out_valid_nxt;
      out_if.out_idx    <= out_idx_nxt;
      out_if.out_onehot <= out_onehot_nxt;
      last              <= last_nxt;
    end
  end

`ifdef PPE_OVERFLOW_EN
  logic [N-1:0] overflow_nxt;

  // A request landing on a bit that is pending and not being cleared is a lost event; clear wins.
  always_comb begin
    overflow_nxt = overflow | (req_i & pending & ~clr);
    if (ovf_clr_i) begin
      overflow_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= '0;
    end else begin
      overflow <= overflow_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Scoreboard bench: fixed-priority and round-robin encoders driven in parallel against a behavioural model.
// Defining PPE_OVERFLOW_EN also checks the overflow flags.
module tb_pending_priority_encoder;
  localparam int N  = 8;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         ready;
  logic [N-1:0] pend_fix, pend_rr;
  logic         ap_fix, ap_rr;
`ifdef PPE_OVERFLOW_EN
  logic         ovf_clr;
  logic [N-1:0] ovf_fix, ovf_rr;
`endif

  pending_priority_encoder_if #(.N(N)) if_fix ();
  pending_priority_encoder_if #(.N(N)) if_rr ();
  assign if_fix.out_ready = ready;
  assign if_rr.out_ready  = ready;

  pending_priority_encoder #(.N(N), .ROUND_ROBIN(1'b0)) u_fix (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .mask_i   (mask),
    .out_if   (if_fix),
    .pending  (pend_fix),
    .any_pend (ap_fix)
`ifdef PPE_OVERFLOW_EN
    ,
    .ovf_clr_i(ovf_clr),
    .overflow (ovf_fix)
`endif
  );

  pending_priority_encoder #(.N(N), .ROUND_ROBIN(1'b1)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .mask_i   (mask),
    .out_if   (if_rr),
    .pending  (pend_rr),
    .any_pend (ap_rr)
`ifdef PPE_OVERFLOW_EN
    ,
    .ovf_clr_i(ovf_clr),
    .overflow (ovf_rr)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one entry per instance (0 = fixed, 1 = round robin).
  bit m_pend [2][N];
  bit m_ovf  [2][N];
  bit m_valid[2];
  int m_idx  [2];
  int m_last [2];
  int q0[$];
  int q1[$];

  task automatic model_step(input int k, input bit rr);
    bit acc;
    int sel;
    int pos;
    int old_idx;
    bit c[N];
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_pend[k][i] = 1'b0;
        m_ovf[k][i]  = 1'b0;
      end
      m_valid[k] = 1'b0;
      m_idx[k]   = 0;
      m_last[k]  = 0;
      return;
    end
    acc     = m_valid[k] && ready;
    old_idx = m_idx[k];
    for (int i = 0; i < N; i++) c[i] = acc && (i == old_idx);
    if (!m_valid[k] || acc) begin
      sel = -1;
      for (int j = 0; j < N; j++) begin
        pos = rr ? (((m_last[k] - 1 - j) % N) + N) % N : N - 1 - j;
        if (sel < 0 && m_pend[k][pos] && !mask[pos] && !c[pos]) sel = pos;
      end
      m_valid[k] = (sel >= 0);
      if (sel >= 0) begin
        m_idx[k] = sel;
        if (k == 0) q0.push_back(sel);
        else        q1.push_back(sel);
      end
    end
    if (acc) m_last[k] = old_idx;
    for (int i = 0; i < N; i++) begin
`ifdef PPE_OVERFLOW_EN
      if (ovf_clr) m_ovf[k][i] = 1'b0;
      else if (req[i] && m_pend[k][i] && !c[i]) m_ovf[k][i] = 1'b1;
`endif
      m_pend[k][i] = (m_pend[k][i] && !c[i]) || req[i];
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 1'b0);
    model_step(1, 1'b1);
  end

  // Monitor: per-cycle state compare plus scoreboard pop on every new grant presentation.
  bit pv[2];
  bit pacc[2];

  task automatic mon(input int k, input string nm, input logic v, input logic [IW-1:0] idx,
                     input logic [N-1:0] oh, input logic [N-1:0] pd, input logic ap);
    logic [N-1:0] exp_p;
    logic [N-1:0] exp_oh;
    int           e;
    int           qs;
    for (int i = 0; i < N; i++) exp_p[i] = m_pend[k][i];
    exp_oh = m_valid[k] ? N'(1) << m_idx[k] : '0;
    chk({nm, ".pending"},    64'(pd),  64'(exp_p));
    chk({nm, ".any_pend"},   64'(ap),  64'(|(exp_p & ~mask)));
    chk({nm, ".out_valid"},  64'(v),   64'(m_valid[k]));
    chk({nm, ".out_idx"},    64'(idx), 64'(m_idx[k]));
    chk({nm, ".out_onehot"}, 64'(oh),  64'(exp_oh));
    if (v === 1'b1 && (!pv[k] || pacc[k])) begin
      qs = (k == 0) ? q0.size() : q1.size();
      chk({nm, ".grant_queue"}, 64'(qs > 0), 64'(1));
      if (qs > 0) begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk({nm, ".grant_idx"}, 64'(idx), 64'(e));
      end
    end
    pv[k]   = (v === 1'b1);
    pacc[k] = (v === 1'b1) && ready;
  endtask

  always @(negedge clk) begin
    mon(0, "fix", if_fix.out_valid, if_fix.out_idx, if_fix.out_onehot, pend_fix, ap_fix);
    mon(1, "rr",  if_rr.out_valid,  if_rr.out_idx,  if_rr.out_onehot,  pend_rr,  ap_rr);
`ifdef PPE_OVERFLOW_EN
    begin
      logic [N-1:0] eo0, eo1;
      for (int i = 0; i < N; i++) begin
        eo0[i] = m_ovf[0][i];
        eo1[i] = m_ovf[1][i];
      end
      chk("fix.overflow", 64'(ovf_fix), 64'(eo0));
      chk("rr.overflow",  64'(ovf_rr),  64'(eo1));
    end
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] m, input logic rdy);
    req   = r;
    mask  = m;
    ready = rdy;
    step();
  endtask

  int rr_exp[8] = '{3, 2, 1, 0, 3, 2, 1, 0};

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    mask  = '0;
    ready = 1'b0;
`ifdef PPE_OVERFLOW_EN
    ovf_clr = 1'b0;
`endif
    // Reset held two cycles with all requests high.
    step();
    step();
    chk("rst.pending",    64'(pend_fix),          64'(8'h00));
    chk("rst.out_valid",  64'(if_fix.out_valid),  64'(0));
    chk("rst.out_idx",    64'(if_fix.out_idx),    64'(0));
    chk("rst.out_onehot", 64'(if_fix.out_onehot), 64'(8'h00));
    rst_n = 1'b1;
    drive('0, '0, 1'b0);
    drive('0, '0, 1'b0);
    chk("post_rst.pending",   64'(pend_fix),         64'(8'h00));
    chk("post_rst.out_valid", 64'(if_fix.out_valid), 64'(0));

    // Fixed priority, two-cycle latency, back-to-back grants.
    drive(8'h14, '0, 1'b1);
    drive(8'h00, '0, 1'b1);
    chk("fp.first_valid",  64'(if_fix.out_valid),  64'(1));
    chk("fp.first_idx",    64'(if_fix.out_idx),    64'(4));
    chk("fp.first_onehot", 64'(if_fix.out_onehot), 64'(8'h10));
    drive(8'h00, '0, 1'b1);
    chk("fp.second_idx",   64'(if_fix.out_idx),    64'(2));
    drive(8'h00, '0, 1'b1);
    chk("fp.drained_valid",   64'(if_fix.out_valid), 64'(0));
    chk("fp.drained_pending", 64'(pend_fix),         64'(8'h00));

    // Backpressure holds the presented index.
    drive(8'h10, '0, 1'b0);
    drive(8'h00, '0, 1'b0);
    chk("bp.idx", 64'(if_fix.out_idx), 64'(4));
    drive(8'h80, '0, 1'b0);
    chk("bp.hold_idx",   64'(if_fix.out_idx),   64'(4));
    chk("bp.hold_valid", 64'(if_fix.out_valid), 64'(1));
    drive(8'h00, '0, 1'b1);
    chk("bp.next_idx", 64'(if_fix.out_idx), 64'(7));
    drive(8'h00, '0, 1'b1);

    // Masked input stays pending but is not selected.
    drive(8'h81, 8'h80, 1'b0);
    drive(8'h00, 8'h80, 1'b0);
    chk("mask.idx",      64'(if_fix.out_idx), 64'(0));
    chk("mask.any_pend", 64'(ap_fix),         64'(1));
    drive(8'h00, 8'h80, 1'b1);
    chk("mask.pending",   64'(pend_fix),         64'(8'h80));
    chk("mask.valid",     64'(if_fix.out_valid), 64'(0));
    chk("mask.any_pend0", 64'(ap_fix),           64'(0));
    drive(8'h00, 8'h00, 1'b0);
    chk("mask.unmasked_idx", 64'(if_fix.out_idx), 64'(7));
    drive(8'h00, 8'h00, 1'b1);
    drive(8'h00, 8'h00, 1'b0);

    // Round robin from a fresh pointer (mid-operation reset first).
    rst_n = 1'b0;
    drive(8'h0F, '0, 1'b1);
    rst_n = 1'b1;
    drive(8'h0F, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(8'h0F, '0, 1'b1);
      chk($sformatf("rr.seq%0d", i), 64'(if_rr.out_idx), 64'(rr_exp[i]));
    end
    for (int i = 0; i < 6; i++) drive('0, '0, 1'b1);

`ifdef PPE_OVERFLOW_EN
    drive(8'h20, '0, 1'b0);
    drive(8'h00, '0, 1'b0);
    drive(8'h20, '0, 1'b0);
    chk("ovf.set", 64'(ovf_fix), 64'(8'h20));
    ovf_clr = 1'b1;
    drive(8'h00, '0, 1'b0);
    ovf_clr = 1'b0;
    chk("ovf.clear", 64'(ovf_fix), 64'(8'h00));
    for (int i = 0; i < 4; i++) drive('0, '0, 1'b1);
`endif

    // Randomised traffic: sparse requests, occasional masks, backpressure and resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      req   = N'($urandom & $urandom & $urandom);
      mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      ready = ($urandom_range(0, 3) != 0);
`ifdef PPE_OVERFLOW_EN
      ovf_clr = ($urandom_range(0, 15) == 0);
`endif
      step();
    end

    rst_n = 1'b1;
`ifdef PPE_OVERFLOW_EN
    ovf_clr = 1'b0;
`endif
    for (int i = 0; i < 20; i++) drive('0, '0, 1'b1);
    @(negedge clk);
    #1;
    chk("fix.queue_left", 64'(q0.size()), 64'(0));
    chk("rr.queue_left",  64'(q1.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pending_priority_encoder.md
Name: pending_priority_encoder

Overview:
Parametrised, registered N-input priority encoder with sticky pending requests, per-input masking and a valid/ready output handshake. Each request is latched into a pending register and served exactly once: the winning index is presented and held until accepted, then its pending bit clears. Fixed-priority (highest index wins) or round-robin selection. Sits between interrupt/event sources and a single consumer (sequencer, interrupt controller).

Parameters:
N, 8, number of request inputs (2..64)
IDX_W, $clog2(N), width of encoded index (derived; not overridden)
ROUND_ROBIN, 0, 0 = fixed priority (highest index wins); 1 = rotating priority

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
req_i  input  N  request pulses/levels; bit i set in a cycle -> pending[i] set
mask_i  input  N  1 = input excluded from selection (still latched as pending)
out_valid  output  1  encoded index available
out_ready  input  1  consumer accepts index when out_valid && out_ready
out_idx  output  IDX_W  encoded index of selected request
out_onehot  output  N  one-hot of out_idx; 0 when out_valid = 0
pending  output  N  current pending register
any_pend  output  1  OR of (pending & ~mask_i), combinational from register and mask

Behaviour:
- Reset (rst_n low at clk edge): pending = 0, out_valid = 0, out_idx = 0, out_onehot = 0, rr pointer last = 0. Synchronous only; mid-operation reset discards all pending and in-flight grant, no acceptance reported.
- accept = out_valid && out_ready; clr = accept ? onehot(out_idx) : 0.
- pending_next = (pending & ~clr) | req_i. Request on a bit in the same cycle it is accepted: bit stays set (new event, served again later).
- Output slot free when !out_valid || accept. When free, at clock edge: cand = pending & ~mask_i & ~clr. If cand != 0: out_valid <= 1, out_idx <= selected index, out_onehot <= onehot; else out_valid <= 0, out_onehot <= 0, out_idx holds.
- While out_valid && !out_ready: out_idx/out_onehot held stable regardless of req_i or mask_i changes.
- Only one index in flight; an in-flight bit is never re-issued before acceptance.
- Latency: req_i bit asserted cycle t -> pending at t+1 -> out_valid at t+2 (idle output). Back-to-back grants every cycle with out_ready held high.
- Fixed priority: highest set index of cand.
- Round robin: search order descending starting at (last-1) mod N, wrapping N-1 after 0; last <= out_idx on accept. With last = 0 after reset, first search starts at N-1 (same as fixed).
- Requests arriving for already-pending bits merge (no count).

Optional Feature:
Macro PPE_OVERFLOW_EN. Defined: adds input ovf_clr_i (1) and output overflow (N); overflow[i] set sticky when req_i[i] = 1 while pending[i] = 1 and clr[i] = 0; cleared to 0 by reset or ovf_clr_i high (clear wins over simultaneous set). Undefined: ports and logic absent; merging silent.

Test Plan:
1. Reset: hold rst_n = 0 two cycles with req_i = 0xFF -> pending = 0x00, out_valid = 0, out_idx = 0, out_onehot = 0x00; after release with req_i = 0, outputs stay 0.
2. Fixed priority, N=8: pulse req_i = 0x14 one cycle, out_ready = 1 -> out_valid at t+2 with out_idx = 4, out_onehot = 0x10; next cycle out_idx = 2; then out_valid = 0, pending = 0x00.
3. Backpressure: pending 0x10, out_ready = 0 -> out_idx = 4 held; pulse req_i = 0x80 -> out_idx stays 4; raise out_ready -> accept 4, next out_idx = 7.
4. Mask: pending 0x81, mask_i = 0x80 -> out_idx = 0, any_pend = 1; after accept, pending = 0x80, out_valid = 0, any_pend = 0; clear mask -> out_idx = 7 one cycle later.
5. Round robin (ROUND_ROBIN=1): req_i = 0x0F held, out_ready = 1 -> grant sequence 3,2,1,0,3,2...
6. PPE_OVERFLOW_EN: pending[5] = 1, out_ready = 0, pulse req_i = 0x20 -> overflow = 0x20; pulse ovf_clr_i -> overflow = 0x00.
